fsm_search_control: RTL and testbench
=====================================

// Module: fsm_search_control
// PURPOSE
//  - Inference-side controller; consumes the query HV built by the encoder FSM.
//  - On encoding_done it reads every class HV from the associative memory (AM), one segment per cycle.
//  - It accumulates per-class overlap scores, tracks the argmax, and returns the winning class on a valid/ready port.
// PARAMETERS
//  NUM_CLASSES   10   number of class HVs stored in AM
//  SEG_COUNT     8    segments per HV (one AM read per segment)
//  SEG_SCORE_W   8    width of per-segment overlap score from popcount unit
//  SCORE_W       16   accumulated score width; elaboration error if < SEG_SCORE_W+$clog2(SEG_COUNT)
//  CLASS_W       $clog2(NUM_CLASSES)   derived; SEG_W = $clog2(SEG_COUNT) derived
// PORTS
//  clk            in   1            system clock
//  nrst           in   1            async active-low reset
//  en             in   1            global enable; low = no new AM reads, counters frozen
//  encoding_done  in   1            1-cycle pulse from encoder FSM: query HV valid
//  am_rd_en       out  1            AM read strobe, one segment per cycle
//  am_class       out  CLASS_W      class index of current read
//  am_seg         out  SEG_W        segment index of current read
//  seg_score      in   SEG_SCORE_W  popcount(query AND class) for the segment read 1 cycle earlier
//  busy           out  1            high in every state except S_IDLE
//  result_valid   out  1            winning class available
//  result_ready   in   1            downstream accepts result
//  result_class   out  CLASS_W      argmax class index
//  result_score   out  SCORE_W      score of argmax class
// BEHAVIOUR
//  - Reset: state S_IDLE; all outputs, counters, accumulator and best registers = 0.
//  - States: S_IDLE, S_SEARCH, S_DRAIN, S_RESULT (typedef enum logic [1:0]).
//  - S_IDLE -> S_SEARCH when encoding_done && en; otherwise stay.
//  - encoding_done in any other state is ignored (no queueing).
//  - S_SEARCH: am_rd_en = en (combinational).
//    - Each enabled cycle issues (class, seg), then advances seg; seg wraps 0 at SEG_COUNT-1 and class increments.
//    - Last read (NUM_CLASSES-1, SEG_COUNT-1) -> S_DRAIN.
//  - am_class/am_seg read 0 outside S_SEARCH.
//  - Response pipe: rd_vld_q, class_q and seg_q are am_rd_en/am_class/am_seg delayed 1 cycle.
//    - seg_score is sampled only when rd_vld_q = 1, regardless of en, so in-flight data is never lost.
//  - Accumulate: acc <= (seg_q==0) ? seg_score : acc + seg_score.
//  - Class complete when seg_q == SEG_COUNT-1; let final = acc + seg_score.
//    - Update best if class_q==0 or final > best_score.
//    - Strict >: ties keep the lower class index.
//  - S_DRAIN: exactly 1 cycle; absorbs the last score, then -> S_RESULT.
//  - S_RESULT: result_valid=1; result_class/result_score hold best and stay stable until result_ready.
//    - Handshake cycle (valid && ready) -> S_IDLE; result_valid low next cycle.
//  - en low in S_DRAIN/S_RESULT has no effect.
//  - Latency with en held high: result_valid rises NUM_CLASSES*SEG_COUNT+2 edges after the edge sampling encoding_done (82 at defaults).
//    - Each en-low cycle in S_SEARCH adds 1.
//  - No overflow possible given the SCORE_W check; no saturation logic.
//  - nrst asserted mid-operation: immediate return to reset values; partial search discarded.
// STRUCTURE
//  - hdc_pkg holds: NUM_CLASSES and SEG_COUNT defaults, SEARCH_STATE enum, derived width localparams.
//  - One sub-module, hdc_argmax: acc, best_class and best_score registers plus compare.
//    - Inputs: score, class, first/last flags, valid.
//  - The FSM and read counters stay in this module.
// TESTING
//  1. Reset: hold nrst low with random inputs -> all outputs 0; after release busy=0 until encoding_done.
//  2. Model seg_score = 10 for class 7, 3 for all others -> result_class=7, result_score=80, valid at edge 82.
//  3. Tie: classes 2 and 5 score 64, others 8 -> result_class=2, result_score=64.
//  4. Hold result_ready low 20 cycles and pulse encoding_done twice -> valid/class/score stable, pulses ignored;
//     ready high -> valid=0 next cycle, busy=0.
//  5. en low 5 cycles at class 3 seg 4 -> am_rd_en=0 during gap, no skipped or repeated (class,seg);
//     same result, valid at edge 87.
//  6. nrst pulse at class 4 -> outputs 0 immediately; new encoding_done -> correct result at edge 82.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared sizing constants and search FSM states for the HDC inference path
package hdc_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int SEG_COUNT   = 8;
    localparam int SEG_SCORE_W = 8;
    localparam int SCORE_W     = 16;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    localparam int SEG_W       = $clog2(SEG_COUNT);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DRAIN, S_RESULT} search_state_t;
endpackage

// File: rtl/fsm_search_control_if.sv
// fsm_search_control_if: AM read port and result valid/ready port of the search controller
interface fsm_search_control_if;
    import hdc_pkg::*;
    logic                   am_rd_en;
    logic [CLASS_W-1:0]     am_class;
    logic [SEG_W-1:0]       am_seg;
    logic [SEG_SCORE_W-1:0] seg_score;
    logic                   result_valid;
    logic                   result_ready;
    logic [CLASS_W-1:0]     result_class;
    logic [SCORE_W-1:0]     result_score;
    modport master (
        output am_rd_en, am_class, am_seg, result_valid, result_class, result_score,
        input  seg_score, result_ready
    );
    modport slave (
        input  am_rd_en, am_class, am_seg, result_valid, result_class, result_score,
        output seg_score, result_ready
    );
endinterface

// File: rtl/hdc_argmax.sv
// hdc_argmax: per-class score accumulator and running argmax; ties keep the lower class
module hdc_argmax
    import hdc_pkg::*;
(
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   valid,
    input  logic                   first,
    input  logic                   last,
    input  logic [SEG_SCORE_W-1:0] score,
    input  logic [CLASS_W-1:0]     cls,
    output logic [CLASS_W-1:0]     best_class,
    output logic [SCORE_W-1:0]     best_score
);
    logic [SCORE_W-1:0] acc, total;
    logic               upd;
    always_comb begin
        total = (first ? '0 : acc) + SCORE_W'(score);
        upd   = valid && last && (cls == '0 || total > best_score);
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc        <= '0;
            best_class <= '0;
            best_score <= '0;
        end else begin
            if (valid) acc <= total;
            if (upd) begin
                best_class <= cls;
                best_score <= total;
            end
        end
    end
endmodule

// File: rtl/fsm_search_control.sv
// fsm_search_control: walks every (class, segment) of the AM after encoding_done and reports the argmax class
module fsm_search_control
    import hdc_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 encoding_done,
    output logic                 busy,
    fsm_search_control_if.master bus
);
    localparam logic [CLASS_W-1:0] CLASS_LAST = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(SEG_COUNT - 1);
    if (SCORE_W < SEG_SCORE_W + SEG_W) begin : g_score_w_check
        $error("SCORE_W too narrow for SEG_COUNT accumulated segment scores");
    end
    search_state_t      state, state_nxt;
    logic [CLASS_W-1:0] cls, class_q, best_class;
    logic [SEG_W-1:0]   seg, seg_q;
    logic [SCORE_W-1:0] best_score;
    logic               rd_vld_q, seg_end, last_rd;
    always_comb begin
        bus.am_rd_en     = state == S_SEARCH && en;
        bus.am_class     = state == S_SEARCH ? cls : '0;
        bus.am_seg       = state == S_SEARCH ? seg : '0;
        seg_end          = seg == SEG_LAST;
        last_rd          = bus.am_rd_en && seg_end && cls == CLASS_LAST;
        busy             = state != S_IDLE;
        bus.result_valid = state == S_RESULT;
        bus.result_class = bus.result_valid ? best_class : '0;
        bus.result_score = bus.result_valid ? best_score : '0;
        state_nxt        = state;
        unique case (state)
            S_IDLE:   state_nxt = encoding_done && en ? S_SEARCH : S_IDLE;
            S_SEARCH: state_nxt = last_rd ? S_DRAIN : S_SEARCH;
            S_DRAIN:  state_nxt = S_RESULT;
            S_RESULT: state_nxt = bus.result_ready ? S_IDLE : S_RESULT;
            default:  state_nxt = S_IDLE;
        endcase
    end
    // Counters wrap back to (0,0) on the last read so the next search starts clean.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            cls      <= '0;
            seg      <= '0;
            rd_vld_q <= 1'b0;
            class_q  <= '0;
            seg_q    <= '0;
        end else begin
            state    <= state_nxt;
            rd_vld_q <= bus.am_rd_en;
            class_q  <= bus.am_class;
            seg_q    <= bus.am_seg;
            if (bus.am_rd_en) begin
                seg <= seg_end ? '0 : seg + 1'b1;
                cls <= seg_end ? (last_rd ? '0 : cls + 1'b1) : cls;
            end
        end
    end
    hdc_argmax u_argmax (
        .clk        (clk),
        .nrst       (nrst),
        .valid      (rd_vld_q),
        .first      (seg_q == '0),
        .last       (seg_q == SEG_LAST),
        .score      (bus.seg_score),
        .cls        (class_q),
        .best_class (best_class),
        .best_score (best_score)
    );
endmodule

// File: tb/tb_fsm_search_control.sv
// tb_fsm_search_control: directed searches against a table-driven AM responder with hand-computed winners
module tb_fsm_search_control;
    import hdc_pkg::*;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b0;
    logic encoding_done = 1'b0;
    logic busy;
    fsm_search_control_if bus();
    fsm_search_control dut (
        .clk           (clk),
        .nrst          (nrst),
        .en            (en),
        .encoding_done (encoding_done),
        .busy          (busy),
        .bus           (bus.master)
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    int tbl [NUM_CLASSES];
    int reads = 0;
    int seq_err = 0;
    logic [CLASS_W-1:0] exp_c = '0;
    logic [SEG_W-1:0]   exp_s = '0;
    // AM model: answers one cycle after the read; 0xFF when idle so stray sampling shows up
    always @(posedge clk)
        bus.seg_score <= bus.am_rd_en ? 8'(tbl[bus.am_class]) : 8'hFF;
    always @(posedge clk) begin
        if (!busy) begin
            reads   <= 0;
            seq_err <= 0;
            exp_c   <= '0;
            exp_s   <= '0;
        end else if (bus.am_rd_en) begin
            reads <= reads + 1;
            if (bus.am_class != exp_c || bus.am_seg != exp_s) seq_err <= seq_err + 1;
            exp_s <= exp_s == SEG_W'(SEG_COUNT - 1) ? '0 : exp_s + 1'b1;
            exp_c <= exp_s == SEG_W'(SEG_COUNT - 1) ? exp_c + 1'b1 : exp_c;
        end
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_tbl(input int a, input int b, input int hi, input int lo);
        for (int i = 0; i < NUM_CLASSES; i++) tbl[i] = (i == a || i == b) ? hi : lo;
    endtask
    function automatic logic [31:0] all_outs();
        return {2'b0, bus.am_rd_en, bus.am_class, bus.am_seg, bus.result_valid,
                bus.result_class, bus.result_score, busy};
    endfunction
    // Edge 1 is the edge sampling encoding_done; result_valid is expected after edge exp_edge
    task automatic search(input string nm, input int exp_edge, input int exp_cls,
                          input int exp_score, input bit gap, input bit hold);
        int  edge_n;
        bit  gapped;
        bit  stable;
        en = 1'b1;
        encoding_done = 1'b1;
        tick();
        encoding_done = 1'b0;
        edge_n = 1;
        gapped = 1'b0;
        while (!bus.result_valid && edge_n < 300) begin
            if (gap && !gapped && bus.am_class == 3 && bus.am_seg == 4) begin
                en = 1'b0;
                gapped = 1'b1;
                repeat (5) begin
                    #1;
                    check({nm, "_gap_rd_en"}, 32'(bus.am_rd_en), 0);
                    tick();
                    edge_n++;
                end
                en = 1'b1;
            end else begin
                tick();
                edge_n++;
            end
        end
        check({nm, "_latency"}, edge_n, exp_edge);
        check({nm, "_class"}, 32'(bus.result_class), exp_cls);
        check({nm, "_score"}, 32'(bus.result_score), exp_score);
        check({nm, "_reads"}, reads, NUM_CLASSES * SEG_COUNT);
        check({nm, "_seq_err"}, seq_err, 0);
        check({nm, "_busy"}, 32'(busy), 1);
        if (hold) begin
            stable = 1'b1;
            for (int i = 0; i < 20; i++) begin
                encoding_done = (i == 5 || i == 12);
                tick();
                if (!bus.result_valid || bus.result_class != CLASS_W'(exp_cls) ||
                    bus.result_score != SCORE_W'(exp_score)) stable = 1'b0;
            end
            encoding_done = 1'b0;
            check({nm, "_hold_stable"}, 32'(stable), 1);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check({nm, "_valid_drop"}, 32'(bus.result_valid), 0);
        check({nm, "_busy_drop"}, 32'(busy), 0);
    endtask
    initial begin
        int n;
        bus.result_ready = 1'b0;
        set_tbl(7, 7, 10, 3);
        repeat (4) begin
            en = 1'($urandom);
            encoding_done = 1'($urandom);
            bus.result_ready = 1'($urandom);
            tick();
            check("rst_outputs", all_outs(), 0);
        end
        en = 1'b0;
        encoding_done = 1'b0;
        bus.result_ready = 1'b0;
        nrst = 1'b1;
        repeat (3) begin
            tick();
            check("idle_busy", 32'(busy), 0);
        end
        search("basic", 82, 7, 80, 1'b0, 1'b0);
        set_tbl(2, 5, 8, 1);
        search("tie", 82, 2, 64, 1'b0, 1'b0);
        set_tbl(0, 0, 5, 4);
        search("hold", 82, 0, 40, 1'b0, 1'b1);
        set_tbl(9, 9, 20, 19);
        search("last_cls", 82, 9, 160, 1'b0, 1'b0);
        set_tbl(0, 0, 255, 255);
        search("max_tie", 82, 0, 2040, 1'b0, 1'b0);
        set_tbl(7, 7, 10, 3);
        search("gap", 87, 7, 80, 1'b1, 1'b0);
        en = 1'b1;
        encoding_done = 1'b1;
        tick();
        encoding_done = 1'b0;
        n = 0;
        while (bus.am_class != 4 && n < 100) begin
            tick();
            n++;
        end
        check("reach_class4", 32'(bus.am_class), 4);
        nrst = 1'b0;
        #1;
        check("midrst_outputs", all_outs(), 0);
        tick();
        nrst = 1'b1;
        tick();
        check("midrst_idle", 32'(busy), 0);
        search("after_rst", 82, 7, 80, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
